// File: rtl/mem_lsu_if.sv
// RAM-side request/acknowledge bus of the load/store unit.
// The LSU drives the request side (master); the memory answers on the slave side.
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    logic                ram_req;
    logic                ram_we;
    logic [XLEN-1:0]     ram_addr;
    logic [XLEN-1:0]     ram_wdata;
    logic [XLEN/8-1:0]   ram_wstrb;
    logic                ram_ack;
    logic [XLEN-1:0]     ram_rdata;

    modport master (
        output ram_req,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output ram_wstrb,
        input  ram_ack,
        input  ram_rdata
    );

    modport slave (
        input  ram_req,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  ram_wstrb,
        output ram_ack,
        output ram_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one access per transaction over a req/ack RAM port, with lane
// steering, sign/zero extension, misalignment detection and an optional timeout.
module mem_lsu #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic                  store_en,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       addr,
    input  logic [REG_ADDR_W-1:0] load_regs_addr,
    input  logic [XLEN-1:0]       store_data,
    mem_lsu_if.master             ram,
    output logic                  regs_write_en,
    output logic [REG_ADDR_W-1:0] regs_write_addr,
    output logic [XLEN-1:0]       regs_write_data,
    output logic                  busy,
    output logic                  unpause_signal,
    output logic                  exc_misalign,
    output logic                  exc_timeout
);

    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_load_q, is_load_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [XLEN-1:0]       ram_addr_q, ram_addr_d;
    logic [XLEN-1:0]       ram_wdata_q, ram_wdata_d;
    logic [NB-1:0]         ram_wstrb_q, ram_wstrb_d;
    logic                  regs_we_q, regs_we_d;
    logic [REG_ADDR_W-1:0] regs_waddr_q, regs_waddr_d;
    logic [XLEN-1:0]       regs_wdata_q, regs_wdata_d;
    logic                  busy_q, busy_d;
    logic                  unpause_q, unpause_d;
    logic                  exc_mis_q, exc_mis_d;
    logic                  exc_to_q, exc_to_d;

    // Request-side decode, evaluated combinationally on the incoming access.
    logic [1:0]            size_in;
    logic [OFF_W-1:0]      off_in;
    logic                  misalign_in;
    logic [XLEN-1:0]       lane_b, lane_h, lane_w;
    logic [XLEN-1:0]       wdata_in;
    logic [NB-1:0]         mask_in;
    logic [NB-1:0]         wstrb_in;
    logic [XLEN-1:0]       ram_addr_in;

    assign size_in     = funct3[1:0];
    assign off_in      = addr[OFF_W-1:0];
    assign ram_addr_in = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        misalign_in = 1'b0;
        case (size_in)
            2'b01:   misalign_in = addr[0];
            2'b10:   misalign_in = |addr[1:0];
            2'b11:   misalign_in = (XLEN == 32) || (|addr[2:0]);
            default: misalign_in = 1'b0;
        endcase
    end

    // Replicate the store operand so whichever lane the strobes select carries it.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign lane_b[gi*8 +: 8] = store_data[7:0];
        assign lane_h[gi*8 +: 8] = store_data[(gi % 2)*8 +: 8];
        assign lane_w[gi*8 +: 8] = store_data[(gi % 4)*8 +: 8];
    end

    always_comb begin
        wdata_in = store_data;
        mask_in  = {NB{1'b1}};
        case (size_in)
            2'b00: begin
                wdata_in = lane_b;
                mask_in  = NB'(1);
            end
            2'b01: begin
                wdata_in = lane_h;
                mask_in  = NB'(3);
            end
            2'b10: begin
                wdata_in = lane_w;
                mask_in  = NB'(15);
            end
            default: begin
                wdata_in = store_data;
                mask_in  = {NB{1'b1}};
            end
        endcase
    end

    assign wstrb_in = mask_in << off_in;

    // Load path: bring the addressed lane down to bit 0, then truncate and extend.
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;
    logic [XLEN-1:0] load_ext;

    assign rshift = ram.ram_rdata >> {off_q, 3'b000};

    always_comb begin
        keep_mask = '1;
        sign_bit  = rshift[XLEN-1];
        case (size_q)
            2'b00: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = rshift[7];
            end
            2'b01: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = rshift[15];
            end
            2'b10: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = rshift[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = rshift[XLEN-1];
            end
        endcase
        load_ext = (rshift & keep_mask) | ((!uns_q && sign_bit) ? ~keep_mask : '0);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        rd_d         = rd_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wstrb_d  = ram_wstrb_q;
        regs_we_d    = 1'b0;
        regs_waddr_d = regs_waddr_q;
        regs_wdata_d = regs_wdata_q;
        busy_d       = busy_q;
        unpause_d    = 1'b0;
        exc_mis_d    = 1'b0;
        exc_to_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_en || store_en) begin
                    // A simultaneous load and store: the load is taken, the store dropped.
                    is_load_d = load_en;
                    size_d    = size_in;
                    uns_d     = funct3[2];
                    off_d     = off_in;
                    rd_d      = load_regs_addr;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    if (misalign_in) begin
                        state_d   = S_RESP;
                        exc_mis_d = 1'b1;
                        unpause_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        ram_req_d   = 1'b1;
                        ram_we_d    = !load_en;
                        ram_addr_d  = ram_addr_in;
                        ram_wdata_d = load_en ? '0 : wdata_in;
                        ram_wstrb_d = load_en ? '0 : wstrb_in;
                    end
                end
            end
            S_REQ: begin
                if (ram.ram_ack) begin
                    state_d     = S_RESP;
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_wstrb_d = '0;
                    unpause_d   = 1'b1;
                    if (is_load_q && (rd_q != '0)) begin
                        regs_we_d    = 1'b1;
                        regs_waddr_d = rd_q;
                        regs_wdata_d = load_ext;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LIM))) begin
                    state_d     = S_RESP;
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_wstrb_d = '0;
                    unpause_d   = 1'b1;
                    exc_to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                ram_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wstrb_q  <= '0;
            regs_we_q    <= 1'b0;
            regs_waddr_q <= '0;
            regs_wdata_q <= '0;
            busy_q       <= 1'b0;
            unpause_q    <= 1'b0;
            exc_mis_q    <= 1'b0;
            exc_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wstrb_q  <= ram_wstrb_d;
            regs_we_q    <= regs_we_d;
            regs_waddr_q <= regs_waddr_d;
            regs_wdata_q <= regs_wdata_d;
            busy_q       <= busy_d;
            unpause_q    <= unpause_d;
            exc_mis_q    <= exc_mis_d;
            exc_to_q     <= exc_to_d;
        end
    end

    assign ram.ram_req      = ram_req_q;
    assign ram.ram_we       = ram_we_q;
    assign ram.ram_addr     = ram_addr_q;
    assign ram.ram_wdata    = ram_wdata_q;
    assign ram.ram_wstrb    = ram_wstrb_q;
    assign regs_write_en    = regs_we_q;
    assign regs_write_addr  = regs_waddr_q;
    assign regs_write_data  = regs_wdata_q;
    assign busy             = busy_q;
    assign unpause_signal   = unpause_q;
    assign exc_misalign     = exc_mis_q;
    assign exc_timeout      = exc_to_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (XLEN=32, TIMEOUT=8): stimulus pushes expected RAM
// requests and responses into queues; monitors pop and compare as the DUT presents them.
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic        store_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  load_regs_addr;
    logic [31:0] store_data;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        busy;
    logic        unpause_signal;
    logic        exc_misalign;
    logic        exc_timeout;

    mem_lsu_if #(.XLEN(32)) ram_bus ();

    mem_lsu #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_en         (load_en),
        .store_en        (store_en),
        .funct3          (funct3),
        .addr            (addr),
        .load_regs_addr  (load_regs_addr),
        .store_data      (store_data),
        .ram             (ram_bus.master),
        .regs_write_en   (regs_write_en),
        .regs_write_addr (regs_write_addr),
        .regs_write_data (regs_write_data),
        .busy            (busy),
        .unpause_signal  (unpause_signal),
        .exc_misalign    (exc_misalign),
        .exc_timeout     (exc_timeout)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          len;
    } req_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        to;
        int          cyc;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_delay = 0;
    logic [31:0] rdata_v = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // RAM model: acknowledges on the (ack_delay+1)-th request cycle; negative never acks.
    int req_cnt = 0;
    initial begin
        ram_bus.ram_ack   = 1'b0;
        ram_bus.ram_rdata = '0;
    end
    always @(negedge clk) begin
        ram_bus.ram_ack = 1'b0;
        if (ram_bus.ram_req) begin
            if (ack_delay >= 0 && req_cnt == ack_delay) begin
                ram_bus.ram_ack   = 1'b1;
                ram_bus.ram_rdata = rdata_v;
            end
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
    end

    // Request monitor: checks fields on the first cycle, stability, busy and length.
    req_t cur_req;
    logic req_active = 1'b0;
    int   req_len = 0;
    logic busy_ok = 1'b1;
    logic stab_ok = 1'b1;
    logic [31:0] first_addr, first_wdata;
    logic [3:0]  first_wstrb;
    logic        first_we;
    always @(negedge clk) begin
        if (ram_bus.ram_req && !req_active) begin
            req_active  = 1'b1;
            req_len     = 1;
            busy_ok     = busy;
            stab_ok     = 1'b1;
            first_we    = ram_bus.ram_we;
            first_addr  = ram_bus.ram_addr;
            first_wdata = ram_bus.ram_wdata;
            first_wstrb = ram_bus.ram_wstrb;
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                cur_req.len = 0;
                $display("FAIL unexpected_req: got ram_req=1 addr 0x%0h required no request", ram_bus.ram_addr);
            end else begin
                cur_req = exp_req.pop_front();
                check("req_we", 64'(ram_bus.ram_we), 64'(cur_req.we));
                check("req_addr", 64'(ram_bus.ram_addr), 64'(cur_req.addr));
                if (cur_req.we) begin
                    check("req_wdata", 64'(ram_bus.ram_wdata), 64'(cur_req.wdata));
                    check("req_wstrb", 64'(ram_bus.ram_wstrb), 64'(cur_req.wstrb));
                end
            end
        end else if (ram_bus.ram_req && req_active) begin
            req_len++;
            if (!busy) busy_ok = 1'b0;
            if (ram_bus.ram_we != first_we || ram_bus.ram_addr != first_addr ||
                ram_bus.ram_wdata != first_wdata || ram_bus.ram_wstrb != first_wstrb)
                stab_ok = 1'b0;
        end else if (!ram_bus.ram_req && req_active) begin
            req_active = 1'b0;
            if (cur_req.len > 0) check("req_len", 64'(req_len), 64'(cur_req.len));
            check("req_busy", 64'(busy_ok), 64'd1);
            check("req_stable", 64'(stab_ok), 64'd1);
        end
    end

    // Response monitor: every unpause pulse must match the next expected response.
    logic unp_prev = 1'b0;
    resp_t cur_resp;
    always @(negedge clk) begin
        if (unpause_signal) begin
            check("unpause_width", 64'(unp_prev), 64'd0);
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got unpause_signal=1 required none");
            end else begin
                cur_resp = exp_resp.pop_front();
                check("resp_cycle", 64'(cyc), 64'(cur_resp.cyc));
                check("resp_wen", 64'(regs_write_en), 64'(cur_resp.wen));
                if (cur_resp.wen) begin
                    check("resp_waddr", 64'(regs_write_addr), 64'(cur_resp.waddr));
                    check("resp_wdata", 64'(regs_write_data), 64'(cur_resp.wdata));
                end
                check("resp_misalign", 64'(exc_misalign), 64'(cur_resp.mis));
                check("resp_timeout", 64'(exc_timeout), 64'(cur_resp.to));
                check("resp_busy", 64'(busy), 64'd1);
            end
        end else if (regs_write_en || exc_misalign || exc_timeout) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse: got wen=%0b mis=%0b to=%0b without unpause_signal",
                     regs_write_en, exc_misalign, exc_timeout);
        end
        unp_prev = unpause_signal;
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_resp.size() == 0) break;
        end
        if (exp_resp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_no_resp: got no response within 60 cycles", tag);
            exp_resp.delete();
        end
        check({tag, "_req_seen"}, 64'(exp_req.size()), 64'd0);
        exp_req.delete();
    endtask

    task automatic run(input string tag,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [4:0] rd, input logic [31:0] sd,
                       input int dly, input logic [31:0] rdat,
                       input logic x_req, input logic x_we, input logic [31:0] x_addr,
                       input logic [31:0] x_wdata, input logic [3:0] x_wstrb, input int x_len,
                       input logic x_wen, input logic [31:0] x_wdat,
                       input logic x_mis, input logic x_to, input int x_lat);
        req_t  q;
        resp_t p;
        int    acc;
        @(posedge clk); #1;
        ack_delay      = dly;
        rdata_v        = rdat;
        load_en        = ld;
        store_en       = st;
        funct3         = f3;
        addr           = a;
        load_regs_addr = rd;
        store_data     = sd;
        @(posedge clk); #1;
        acc      = cyc;
        load_en  = 1'b0;
        store_en = 1'b0;
        if (x_req) begin
            q.we = x_we; q.addr = x_addr; q.wdata = x_wdata; q.wstrb = x_wstrb; q.len = x_len;
            exp_req.push_back(q);
        end
        p.wen = x_wen; p.waddr = rd; p.wdata = x_wdat; p.mis = x_mis; p.to = x_to; p.cyc = acc + x_lat;
        exp_resp.push_back(p);
        $display("txn %s: ld=%0b st=%0b f3=%03b addr=0x%08h rd=%0d sd=0x%08h", tag, ld, st, f3, a, rd, sd);
        drain(tag);
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        load_en        = 1'b0;
        store_en       = 1'b0;
        funct3         = 3'b000;
        addr           = '0;
        load_regs_addr = '0;
        store_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({ram_bus.ram_req, ram_bus.ram_we, ram_bus.ram_wstrb, regs_write_en,
                                 regs_write_addr, busy, unpause_signal, exc_misalign, exc_timeout}), 64'd0);
        check("reset_ram", {ram_bus.ram_addr, ram_bus.ram_wdata}, 64'd0);
        check("reset_wdata", 64'(regs_write_data), 64'd0);
        rst_n = 1'b1;

        //   tag     ld st f3      addr          rd sd            dly rdata          req we raddr         rwdata        strb    len wen wdata          mis to lat
        run("lw",    1, 0, 3'b010, 32'h100, 5, 32'h0,        0, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        4'b0000, 1, 1, 32'hDEADBEEF, 0, 0, 1);
        run("lb",    1, 0, 3'b000, 32'h103, 6, 32'h0,        1, 32'h80FF0000, 1, 0, 32'h100, 32'h0,        4'b0000, 2, 1, 32'hFFFFFF80, 0, 0, 2);
        run("lbu",   1, 0, 3'b100, 32'h103, 6, 32'h0,        0, 32'h80FF0000, 1, 0, 32'h100, 32'h0,        4'b0000, 1, 1, 32'h00000080, 0, 0, 1);
        run("lh",    1, 0, 3'b001, 32'h102, 6, 32'h0,        0, 32'h80FF0000, 1, 0, 32'h100, 32'h0,        4'b0000, 1, 1, 32'hFFFF80FF, 0, 0, 1);
        run("lhu",   1, 0, 3'b101, 32'h100, 8, 32'h0,        0, 32'h80FF8001, 1, 0, 32'h100, 32'h0,        4'b0000, 1, 1, 32'h00008001, 0, 0, 1);
        run("sb",    0, 1, 3'b000, 32'h101, 0, 32'h000000A5, 4, 32'h0,        1, 1, 32'h100, 32'hA5A5A5A5, 4'b0010, 5, 0, 32'h0,        0, 0, 5);
        run("sh",    0, 1, 3'b001, 32'h102, 0, 32'h1234ABCD, 2, 32'h0,        1, 1, 32'h100, 32'hABCDABCD, 4'b1100, 3, 0, 32'h0,        0, 0, 3);
        run("sw",    0, 1, 3'b010, 32'h108, 0, 32'h11223344, 0, 32'h0,        1, 1, 32'h108, 32'h11223344, 4'b1111, 1, 0, 32'h0,        0, 0, 1);
        run("lw_mis",1, 0, 3'b010, 32'h102, 5, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 0, 32'h0,        1, 0, 0);
        run("sh_mis",0, 1, 3'b001, 32'h101, 0, 32'hFFFF,     0, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 0, 32'h0,        1, 0, 0);
        run("ld_ill",1, 0, 3'b011, 32'h100, 5, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 0, 32'h0,        1, 0, 0);
        run("tmo",   1, 0, 3'b010, 32'h104, 4, 32'h0,       -1, 32'h0,        1, 0, 32'h104, 32'h0,        4'b0000, 8, 0, 32'h0,        0, 1, 8);
        run("ld_st", 1, 1, 3'b010, 32'h200, 7, 32'h1234,     0, 32'h12345678, 1, 0, 32'h200, 32'h0,        4'b0000, 1, 1, 32'h12345678, 0, 0, 1);

        // Abandon a request mid-flight with a one-cycle reset.
        @(posedge clk); #1;
        ack_delay      = -1;
        load_en        = 1'b1;
        funct3         = 3'b010;
        addr           = 32'h300;
        load_regs_addr = 5'd9;
        @(posedge clk); #1;
        load_en = 1'b0;
        cur_req.len = 0;
        exp_req.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, wstrb: 4'b0, len: 0});
        $display("txn rst_mid: LW addr=0x00000300 rd=9, reset while requesting");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ctrl", 64'({ram_bus.ram_req, ram_bus.ram_we, ram_bus.ram_wstrb, regs_write_en,
                                  regs_write_addr, busy, unpause_signal, exc_misalign, exc_timeout}), 64'd0);
        check("midrst_ram", {ram_bus.ram_addr, ram_bus.ram_wdata}, 64'd0);
        check("midrst_wdata", 64'(regs_write_data), 64'd0);
        @(negedge clk);
        check("midrst_req_seen", 64'(exp_req.size()), 64'd0);
        exp_req.delete();

        run("lw_post", 1, 0, 3'b010, 32'h104, 3, 32'h0, 0, 32'hCAFEF00D, 1, 0, 32'h104, 32'h0, 4'b0000, 1, 1, 32'hCAFEF00D, 0, 0, 1);
        run("lw_x0",   1, 0, 3'b010, 32'h104, 0, 32'h0, 1, 32'h55AA55AA, 1, 0, 32'h104, 32'h0, 4'b0000, 2, 0, 32'h0,        0, 0, 2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
